// File: rtl/calc_pkg.sv
// Shared definitions for the single-digit calculator entry path.
// Holds the key code map, the operator encoding driven to the arithmetic
// units, the entry FSM state type and the result bus width.
package calc_pkg;

  localparam int RES_W = 8;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EQ   = 3'd3,
    S_SHOW = 3'd4
  } state_t;

endpackage

// File: rtl/calc_key_class.sv
// Combinational key classifier.
// Ports:
//   key_code  in   4  raw key code
//   is_digit  out  1  code 0-9
//   is_op     out  1  code 10-13 (add/sub/mul/div)
//   is_eq     out  1  code 14
//   is_clr    out  1  code 15
//   op_fld    out  2  operator encoding (code-10), meaningful when is_op
module calc_key_class
  import calc_pkg::*;
(
  input  logic [3:0] key_code,
  output logic       is_digit,
  output logic       is_op,
  output logic       is_eq,
  output logic       is_clr,
  output logic [1:0] op_fld
);

  always_comb begin
    is_digit = (key_code <= 4'd9);
    is_op    = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
    is_eq    = (key_code == KEY_EQ);
    is_clr   = (key_code == KEY_CLR);
    // Codes 10..13 are 4'b10xx/4'b11xx; flipping bit 1 of the low pair
    // gives code-10 without a subtractor.
    op_fld   = key_code[1:0] ^ 2'b10;
  end

endmodule

// File: rtl/calc_entry_seq.sv
// Key-entry sequencer for the single-digit calculator.
// Holds the two BCD operands and the operator feeding the arithmetic units
// and latches the selected unit's result on '='.
// Ports:
//   clk           in   1      system clock
//   rst           in   1      asynchronous active-high reset
//   key_valid     in   1      key strobe
//   key_code      in   4      key code (0-9 digit, 10-13 op, 14 '=', 15 clear)
//   res_in        in   RES_W  result of the unit selected by op
//   dig1, dig2    out  4      operands to the arithmetic units
//   op            out  2      operator select
//   result        out  RES_W  latched result
//   result_valid  out  1      result being shown
//   err           out  1      shown result is a divide-by-zero
//   state         out  3      current FSM state
//
// state  | meaning
// S_A    | waiting for the first digit
// S_OP   | first digit held, waiting for an operator
// S_B    | waiting for the second digit
// S_EQ   | second digit held, waiting for '='
// S_SHOW | result displayed
module calc_entry_seq #(
  parameter int RES_W = calc_pkg::RES_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic [RES_W-1:0] res_in,
  output logic [3:0]       dig1,
  output logic [3:0]       dig2,
  output logic [1:0]       op,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  output logic             err,
  output logic [2:0]       state
);
  import calc_pkg::*;

  logic       is_digit, is_op, is_eq, is_clr;
  logic [1:0] op_fld;

  state_t           state_q, state_n;
  logic [3:0]       dig1_n, dig2_n;
  logic [1:0]       op_n;
  logic [RES_W-1:0] result_n;
  logic             result_valid_n, err_n;

  calc_key_class u_key_class (
    .key_code (key_code),
    .is_digit (is_digit),
    .is_op    (is_op),
    .is_eq    (is_eq),
    .is_clr   (is_clr),
    .op_fld   (op_fld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_A;
      dig1         <= '0;
      dig2         <= '0;
      op           <= OP_ADD;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_n;
      dig1         <= dig1_n;
      dig2         <= dig2_n;
      op           <= op_n;
      result       <= result_n;
      result_valid <= result_valid_n;
      err          <= err_n;
    end
  end

  always_comb begin
    state_n        = state_q;
    dig1_n         = dig1;
    dig2_n         = dig2;
    op_n           = op;
    result_n       = result;
    result_valid_n = result_valid;
    err_n          = err;

    if (key_valid) begin
      if (is_clr) begin
        state_n        = S_A;
        dig1_n         = '0;
        dig2_n         = '0;
        op_n           = OP_ADD;
        result_n       = '0;
        result_valid_n = 1'b0;
        err_n          = 1'b0;
      end else begin
        unique case (state_q)
          S_A: begin
            if (is_digit) begin
              dig1_n  = key_code;
              state_n = S_OP;
            end
          end
          S_OP: begin
            if (is_digit) begin
              dig1_n = key_code;
            end else if (is_op) begin
              op_n    = op_fld;
              state_n = S_B;
            end
          end
          S_B: begin
            if (is_digit) begin
              dig2_n  = key_code;
              state_n = S_EQ;
            end else if (is_op) begin
              op_n = op_fld;
            end
          end
          S_EQ: begin
            if (is_digit) begin
              dig2_n = key_code;
            end else if (is_eq) begin
              state_n        = S_SHOW;
              result_valid_n = 1'b1;
              // Operands are registered, so the divide-by-zero test uses
              // the same values the arithmetic units see this cycle.
              if (op == OP_DIV && dig2 == 4'd0) begin
                result_n = '0;
                err_n    = 1'b1;
              end else begin
                result_n = res_in;
                err_n    = 1'b0;
              end
            end
          end
          S_SHOW: begin
            if (is_digit) begin
              dig1_n         = key_code;
              dig2_n         = '0;
              op_n           = OP_ADD;
              result_valid_n = 1'b0;
              err_n          = 1'b0;
              state_n        = S_OP;
            end
          end
          default: state_n = S_A;
        endcase
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_calc_entry_seq.sv
module tb_calc_entry_seq;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] res_in;
  logic [3:0] dig1, dig2;
  logic [1:0] op;
  logic [7:0] result;
  logic       result_valid, err;
  logic [2:0] state;

  calc_entry_seq #(.RES_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .res_in       (res_in),
    .dig1         (dig1),
    .dig2         (dig2),
    .op           (op),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Behaviour of the arithmetic units downstream of the sequencer.
  function automatic logic [7:0] arith(logic [3:0] a, logic [3:0] b, logic [1:0] o);
    case (o)
      2'd0:    return 8'(a) + 8'(b);
      2'd1:    return 8'(a) - 8'(b);
      2'd2:    return 8'(a) * 8'(b);
      default: return (b == 4'd0) ? 8'hFF : 8'(a) / 8'(b);
    endcase
  endfunction

  always_comb res_in = arith(dig1, dig2, op);

  typedef struct {
    logic [3:0] d1;
    logic [3:0] d2;
    logic [1:0] o;
    logic [7:0] res;
    logic       rv;
    logic       er;
    logic [2:0] st;
  } snap_t;

  typedef struct {
    logic [7:0] res;
    logic       er;
  } rexp_t;

  snap_t model;
  snap_t snap_q[$];
  rexp_t res_q[$];
  int    tests = 0;
  int    fails = 0;

  task automatic model_reset();
    model.d1  = 4'd0;
    model.d2  = 4'd0;
    model.o   = 2'd0;
    model.res = 8'd0;
    model.rv  = 1'b0;
    model.er  = 1'b0;
    model.st  = S_A;
  endtask

  task automatic model_key(logic [3:0] k);
    bit dig, opk;
    rexp_t r;
    dig = (k <= 4'd9);
    opk = (k >= 4'd10 && k <= 4'd13);
    if (k == 4'd15) begin
      model_reset();
    end else begin
      case (model.st)
        S_A: if (dig) begin model.d1 = k; model.st = S_OP; end
        S_OP: begin
          if (dig) model.d1 = k;
          else if (opk) begin model.o = 2'(k - 4'd10); model.st = S_B; end
        end
        S_B: begin
          if (dig) begin model.d2 = k; model.st = S_EQ; end
          else if (opk) model.o = 2'(k - 4'd10);
        end
        S_EQ: begin
          if (dig) model.d2 = k;
          else if (k == 4'd14) begin
            if (model.o == 2'd3 && model.d2 == 4'd0) begin
              r.res = 8'd0; r.er = 1'b1;
            end else begin
              r.res = arith(model.d1, model.d2, model.o); r.er = 1'b0;
            end
            model.res = r.res;
            model.er  = r.er;
            model.rv  = 1'b1;
            model.st  = S_SHOW;
            res_q.push_back(r);
          end
        end
        default: if (dig) begin
          model.d1 = k; model.d2 = 4'd0; model.o = 2'd0;
          model.rv = 1'b0; model.er = 1'b0; model.st = S_OP;
        end
      endcase
    end
  endtask

  task automatic check(string nm, snap_t e);
    tests++;
    if (dig1 !== e.d1 || dig2 !== e.d2 || op !== e.o || result !== e.res ||
        result_valid !== e.rv || err !== e.er || state !== e.st) begin
      fails++;
      $display("FAIL %s: got d1=%0d d2=%0d op=%0d res=%0d rv=%0d err=%0d st=%0d, want d1=%0d d2=%0d op=%0d res=%0d rv=%0d err=%0d st=%0d",
               nm, dig1, dig2, op, result, result_valid, err, state,
               e.d1, e.d2, e.o, e.res, e.rv, e.er, e.st);
    end
  endtask

  task automatic drive(bit kv, logic [3:0] k);
    @(negedge clk);
    key_valid = kv;
    key_code  = k;
    if (kv) model_key(k);
    snap_q.push_back(model);
  endtask

  task automatic key(logic [3:0] k);
    drive(1'b1, k);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'($urandom));
  endtask

  // Monitor: snapshot after every driven cycle, result check on each new result.
  initial begin
    logic  rv_prev;
    snap_t e;
    rexp_t r;
    rv_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (snap_q.size() > 0) begin
        e = snap_q.pop_front();
        check("cycle", e);
      end
      if (result_valid && !rv_prev) begin
        tests++;
        if (res_q.size() == 0) begin
          fails++;
          $display("FAIL result: unexpected result_valid, result=%0d err=%0d", result, err);
        end else begin
          r = res_q.pop_front();
          if (result !== r.res || err !== r.er) begin
            fails++;
            $display("FAIL result: got %0d err=%0d, want %0d err=%0d", result, err, r.res, r.er);
          end
        end
      end
      rv_prev = result_valid;
    end
  end

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    model_reset();
    #1;
    check("reset", model);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    key(7); key(13); key(2); key(14); idle(2);
    key(15);
    key(5); key(13); key(0); key(14); idle(2);
    key(15);
    key(4); key(3); key(10); key(12); key(9); key(14); idle(2);
    key(6); key(14); idle(2);
    key(15); key(14); key(10); idle(1);
    key(1); key(10); key(2); key(15); idle(1);
    key(2); key(10); idle(1);

    // Asynchronous reset mid-cycle while in S_B.
    @(negedge clk);
    key_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst", model);
    #1 rst = 1'b0;

    key(8); key(11); key(1); key(14); idle(2);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [3:0] k;
      r = $urandom_range(0, 99);
      if (r < 50)      k = 4'($urandom_range(0, 9));
      else if (r < 97) k = 4'($urandom_range(10, 14));
      else             k = 4'd15;
      drive($urandom_range(0, 3) != 0, k);
    end
    idle(3);

    for (int i = 0; i < 20 && snap_q.size() > 0; i++) @(posedge clk);
    #2;
    tests++;
    if (snap_q.size() != 0 || res_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d snapshots and %0d results left, want 0", snap_q.size(), res_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_entry_seq.md
# calc_entry_seq

Key-entry sequencer for the single-digit calculator. It sits directly upstream of the arithmetic units (add, sub, mul, div). It accepts one key code per strobe and holds the two BCD operands and the selected operator in registers that drive those units. On '=' it captures the selected unit's result, together with a divide-by-zero flag, for the display stage.

## Interface
Parameters:
- RES_W, 8, width of the result bus from the arithmetic mux (max product 81 fits in 8 bits).

Ports:
- clk  input  1  system clock; single clock domain, all state on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- key_valid  input  1  one-cycle strobe; key_code is sampled only when high.
- key_code  input  4  key codes:
  - 0-9: digit.
  - 10: add. 11: sub. 12: mul. 13: div.
  - 14: equals. 15: clear.
- res_in  input  RES_W  combinational result of the unit selected by op, a function of dig1/dig2/op.
- dig1  output  4  first operand (BCD, 0-9) to the arithmetic units.
- dig2  output  4  second operand (BCD, 0-9) to the arithmetic units.
- op  output  2  operator select: 0 add, 1 sub, 2 mul, 3 div.
- result  output  RES_W  latched result.
- result_valid  output  1  high while the latched result is being shown.
- err  output  1  high while showing a divide-by-zero result.
- state  output  3  current FSM state encoding, for the display stage.

## Operation
- FSM states: S_A, S_OP, S_B, S_EQ, S_SHOW.
  - S_A: waiting for the first digit.
  - S_OP: first digit held, waiting for an operator.
  - S_B: waiting for the second digit.
  - S_EQ: second digit held, waiting for '='.
  - S_SHOW: result displayed.
- Transitions happen only on a cycle with key_valid=1. Keys not listed for a state are ignored: no register changes.
- S_A:
  - digit d -> dig1<=d, go to S_OP.
- S_OP:
  - digit d -> dig1<=d (overwrite), stay in S_OP.
  - operator -> op<=code-10, go to S_B.
- S_B:
  - digit d -> dig2<=d, go to S_EQ.
  - operator -> op replaced, stay in S_B.
- S_EQ:
  - digit d -> dig2<=d (overwrite), stay in S_EQ.
  - equals -> go to S_SHOW and capture the result:
    - if op==3 and dig2==0: result<=0, err<=1.
    - otherwise: result<=res_in, err<=0.
    - result_valid<=1 in both cases.
- S_SHOW:
  - digit d -> new calculation: dig1<=d, dig2<=0, op<=0, result_valid<=0, err<=0, go to S_OP.
  - operators and equals are ignored; no chaining.
- Clear (15) in any state performs the same action as reset, synchronously: all outputs go to their reset values and the FSM goes to S_A.
- The result and err values are held unchanged while in S_SHOW.
- res_in is sampled only on the equals cycle. The operands are already registered and stable on that cycle, so no wait state is needed.

## Timing
- Reset values: dig1=0, dig2=0, op=0, result=0, result_valid=0, err=0, state=S_A.
- Every operand, op and state update is visible in the cycle after the accepted key strobe.
- result_valid and err rise one cycle after the accepted '=' strobe; result is valid in that same cycle.
- result_valid falls one cycle after a digit is accepted in S_SHOW, or after clear.
- Back-to-back strobes on consecutive cycles are all honoured in order; no minimum gap between keys.
- Asserting rst mid-entry clears everything immediately, without waiting for a clock edge; the first key after rst deasserts is processed normally.
- key_valid=0: full hold of all state and outputs.

## Structure
- Shared package calc_pkg holds:
  - key code constants: KEY_ADD=10, KEY_SUB=11, KEY_MUL=12, KEY_DIV=13, KEY_EQ=14, KEY_CLR=15.
  - the op encoding constants.
  - the FSM state enum.
  - RES_W.
- One sub-module is natural: calc_key_class. It is combinational and classifies key_code into is_digit/is_op/is_eq/is_clr plus a 2-bit op field. The FSM lives in calc_entry_seq.

## Test plan
- Reset then keys 7, 13, 2, 14 with res_in=3 -> dig1=7, op=3, dig2=2; next cycle result=3, result_valid=1, err=0, state=S_SHOW.
- Keys 5, 13, 0, 14 with res_in=0xFF -> result=0, err=1, result_valid=1.
- Keys 4, 3, 10, 12, 9, 14 with res_in=27 -> dig1=3 (digit overwritten), op=2 (operator replaced), result=27.
- In S_SHOW key 6 -> dig1=6, dig2=0, op=0, result_valid=0, state=S_OP; a following 14 is ignored.
- Keys 14 and 10 in S_A ignored (state stays S_A); key 15 in S_EQ -> all outputs back to their reset values.
- rst pulsed asynchronously between clock edges while in S_B -> outputs are at reset values before the next edge; the sequence 8, 11, 1, 14 afterwards works, capturing res_in=7.
